// File: rtl/servo_pkg.sv
// Shared state encoding and default timing for the barrier servo ramp driver.
package servo_pkg;

  typedef enum logic [1:0] {
    StClosed,
    StOpening,
    StOpen,
    StClosing
  } servo_state_t;

  // Defaults assume a 25 MHz clock: 20 ms frame, 1 ms closed, 2 ms open, 1 s full travel.
  localparam int unsigned DefPeriodTicks = 500000;
  localparam int unsigned DefPwClosed    = 25000;
  localparam int unsigned DefPwOpen      = 50000;
  localparam int unsigned DefStep        = 500;
  localparam int unsigned DefHoldFrames  = 100;

endpackage

// File: rtl/servo_frame_timer.sv
// PWM frame counter: counts 0..PERIOD_TICKS-1 and flags the last cycle of each frame.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_TICKS = DefPeriodTicks,
  parameter int unsigned CNT_W        = $clog2(PERIOD_TICKS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt_next,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(PERIOD_TICKS - 1);

  logic [CNT_W-1:0] cnt_q;

  assign frame_end = (cnt_q == LastCnt);
  assign cnt_next  = frame_end ? '0 : cnt_q + CNT_W'(1);

  // Reset parks on the last count so the release edge is itself a frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= LastCnt;
    end else begin
      cnt_q <= cnt_next;
    end
  end

endmodule

// File: rtl/servo_ramp_driver.sv
// Barrier servo driver: ramps the PWM pulse width one STEP per frame between closed and open.
// Optional SERVO_HOLD_RELEASE_EN de-energizes the servo after HOLD_FRAMES idle frames.
module servo_ramp_driver
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_TICKS = DefPeriodTicks,
  parameter int unsigned PW_CLOSED    = DefPwClosed,
  parameter int unsigned PW_OPEN      = DefPwOpen,
  parameter int unsigned STEP         = DefStep,
  parameter int unsigned HOLD_FRAMES  = DefHoldFrames
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_open,
  output logic SERVO,
  output logic pos_open,
  output logic pos_closed,
  output logic busy
);

  localparam int unsigned CntW = $clog2(PERIOD_TICKS) + 1;
  localparam logic [CntW-1:0] PwClosedW = CntW'(PW_CLOSED);
  localparam logic [CntW-1:0] PwOpenW   = CntW'(PW_OPEN);
  localparam logic [CntW-1:0] StepW     = CntW'(STEP);

  logic [CntW-1:0] cnt_next;
  logic            frame_end;
  servo_state_t    state_q, state_d;
  logic [CntW-1:0] pw_q, pw_d, pw_up, pw_dn;
  logic            servo_q, servo_d, pulse_en;
  logic            pos_open_q, pos_closed_q, busy_q;

  servo_frame_timer #(
    .PERIOD_TICKS(PERIOD_TICKS),
    .CNT_W       (CntW)
  ) u_frame_timer (
    .clk      (clk),
    .rst      (rst),
    .cnt_next (cnt_next),
    .frame_end(frame_end)
  );

  // Saturating ramp steps; clamping before subtraction keeps pw from underflowing.
  assign pw_up = (pw_q + StepW >= PwOpenW) ? PwOpenW : pw_q + StepW;
  assign pw_dn = (pw_q < PwClosedW + StepW) ? PwClosedW : pw_q - StepW;

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    if (frame_end) begin
      case (state_q)
        StClosed: begin
          if (cmd_open) begin
            state_d = StOpening;
            pw_d    = pw_up;
          end
        end
        StOpen: begin
          if (!cmd_open) begin
            state_d = StClosing;
            pw_d    = pw_dn;
          end
        end
        StOpening: begin
          if (cmd_open) begin
            pw_d = pw_up;
            if (pw_up == PwOpenW) state_d = StOpen;
          end else begin
            state_d = StClosing;
            pw_d    = pw_dn;
          end
        end
        StClosing: begin
          if (!cmd_open) begin
            pw_d = pw_dn;
            if (pw_dn == PwClosedW) state_d = StClosed;
          end else begin
            state_d = StOpening;
            pw_d    = pw_up;
          end
        end
        default: begin
          state_d = StClosed;
          pw_d    = PwClosedW;
        end
      endcase
    end
  end

`ifdef SERVO_HOLD_RELEASE_EN
  localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 2);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_FRAMES);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             fresh_q, held_q, held_d, settled;

  // The frame right after reset counts like a freshly entered state.
  assign settled = !fresh_q && (state_d == state_q) &&
                   ((state_q == StOpen) || (state_q == StClosed));

  always_comb begin
    hold_d = hold_q;
    held_d = held_q;
    if (frame_end) begin
      if (!settled) begin
        hold_d = '0;
      end else if (hold_q != HoldMax) begin
        hold_d = hold_q + HoldW'(1);
      end
      held_d = settled && (hold_d >= HoldMax);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      held_q  <= 1'b0;
      fresh_q <= 1'b1;
    end else begin
      hold_q <= hold_d;
      held_q <= held_d;
      if (frame_end) fresh_q <= 1'b0;
    end
  end

  assign pulse_en = !held_d;
`else
  logic unused_hold_frames;
  assign unused_hold_frames = ^HOLD_FRAMES;
  assign pulse_en = 1'b1;
`endif

  // Compare against next-cycle count/width so SERVO is registered yet aligned with cnt.
  assign servo_d = (cnt_next < pw_d) && pulse_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StClosed;
      pw_q         <= PwClosedW;
      servo_q      <= 1'b0;
      pos_open_q   <= 1'b0;
      pos_closed_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pw_q         <= pw_d;
      servo_q      <= servo_d;
      pos_open_q   <= (state_d == StOpen);
      pos_closed_q <= (state_d == StClosed);
      busy_q       <= (state_d == StOpening) || (state_d == StClosing);
    end
  end

  assign SERVO      = servo_q;
  assign pos_open   = pos_open_q;
  assign pos_closed = pos_closed_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_servo_ramp_driver.sv
// Scoreboard bench: stimulus queues expected per-frame pulse width and status flags,
// a monitor measures each 100-cycle frame and compares.
module tb_servo_ramp_driver;

  localparam int unsigned Period = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_open = 1'b0;
  logic SERVO, pos_open, pos_closed, busy;

  // Flags packed as {pos_open, pos_closed, busy}.
  localparam logic [2:0] FOpen   = 3'b100;
  localparam logic [2:0] FClosed = 3'b010;
  localparam logic [2:0] FBusy   = 3'b001;

  typedef struct {
    int         w;
    logic [2:0] f;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  servo_ramp_driver #(
    .PERIOD_TICKS(100),
    .PW_CLOSED   (10),
    .PW_OPEN     (20),
    .STEP        (4),
    .HOLD_FRAMES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_open  (cmd_open),
    .SERVO     (SERVO),
    .pos_open  (pos_open),
    .pos_closed(pos_closed),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: frames start on the first cycle after the reset-release edge.
  int         pos = 0;
  int         hi, rises, first;
  logic       prev;
  logic [2:0] flags;
  exp_t       e;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      pos = 0;
    end else begin
      if (pos == 0) begin
        flags = {pos_open, pos_closed, busy};
        hi    = 0;
        rises = 0;
        first = -1;
        prev  = 1'b0;
      end
      if (SERVO) begin
        hi++;
        if (!prev) begin
          rises++;
          if (first < 0) first = pos;
        end
      end
      prev = SERVO;
      pos++;
      if (pos == Period) begin
        pos = 0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("frame_width", hi, e.w);
          chk("frame_flags", int'(flags), int'(e.f));
          chk("frame_shape", (e.w == 0) ? int'(rises == 0) : int'(rises == 1 && first == 0), 1);
        end
      end
    end
  end

  // Called at a negedge; asserts reset for one edge and checks the reset outputs.
  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_servo", SERVO, 0);
    chk("rst_pos_closed", pos_closed, 1);
    chk("rst_pos_open", pos_open, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at the negedge before a frame-end edge; cmd is what that edge samples.
  task automatic run_frame(input logic cmd, input int tog_lo, input int tog_hi,
                           input int w, input logic [2:0] f);
    exp_t x;
    x.w = w;
    x.f = f;
    cmd_open = cmd;
    sb.push_back(x);
    for (int i = 0; i < Period; i++) begin
      @(negedge clk);
      if (i == tog_lo) cmd_open = !cmd;
      if (i == tog_hi) cmd_open = cmd;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);

    // Idle closed after reset.
    apply_reset();
    for (int k = 0; k < 3; k++) run_frame(1'b0, -1, -1, 10, FClosed);

    // Full opening ramp.
    @(negedge clk);
    apply_reset();
    run_frame(1'b1, -1, -1, 14, FBusy);
    run_frame(1'b1, -1, -1, 18, FBusy);
    run_frame(1'b1, -1, -1, 20, FOpen);
    run_frame(1'b1, -1, -1, 20, FOpen);

    // Reversal mid-travel, then mid-frame command glitches ignored.
    apply_reset();
    run_frame(1'b1, -1, -1, 14, FBusy);
    run_frame(1'b0, -1, -1, 10, FBusy);
    run_frame(1'b0, -1, -1, 10, FClosed);
    run_frame(1'b0, 30, 60, 10, FClosed);
    run_frame(1'b0, 35, 55, 10, FClosed);

    // Reset in the middle of an 18-cycle pulse.
    apply_reset();
    run_frame(1'b1, -1, -1, 14, FBusy);
    cmd_open = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("servo_mid_pulse", SERVO, 1);
    apply_reset();
    run_frame(1'b0, -1, -1, 10, FClosed);

    // Long idle in CLOSED, then open.
    apply_reset();
    run_frame(1'b0, -1, -1, 10, FClosed);
    run_frame(1'b0, -1, -1, 10, FClosed);
    run_frame(1'b0, -1, -1, 10, FClosed);
`ifdef SERVO_HOLD_RELEASE_EN
    run_frame(1'b0, -1, -1, 0, FClosed);
`else
    run_frame(1'b0, -1, -1, 10, FClosed);
`endif
    run_frame(1'b1, -1, -1, 14, FBusy);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
